dac_frame_scheduler: RTL and testbench
======================================

// Module: dac_frame_scheduler
// PURPOSE
//  Collects per-channel sample words from independent producers: PI controller output, raw ADC passthrough and monitor taps.
//  Launches one frame at a time into the shared 4-channel AD5541A serializer (dacs_ad5541a), gated by its busy handshake.
//  Sits in the ADC_outclock_50 domain between the controller/ADC datapath and the DAC serializer.
//  Reports frame, overrun and handshake-timeout status for LEDs and the network status words.
// PARAMETERS
//  N_CH         4      number of DAC channels (one serializer frame = N_CH words)
//  DATA_W       16     sample width, two's complement in
//  MIN_GAP      8      idle cycles enforced after busy falls before the next launch (1..255)
//  ACK_TIMEOUT  64     cycles allowed for busy to rise after dac_start (>=2)
// PORTS
//  clk            in   1            ADC_outclock_50
//  reset_n        in   1            asynchronous, active-low reset
//  enable         in   1            allow new launches; an in-flight frame always completes
//  ch_mask        in   N_CH         channels that must be fresh before a launch; 0 = never launch
//  ch_data        in   N_CH*DATA_W  signed samples, ch0 in [DATA_W-1:0]
//  ch_valid       in   N_CH         1-cycle strobe per channel; latches ch_data slice
//  dac_busy       in   1            serializer busy
//  dac_start      out  1            1-cycle launch pulse to serializer
//  dac_data       out  N_CH*DATA_W  offset-binary frame words, stable from dac_start until next launch
//  frame_count    out  16           launched frames, wraps 0xFFFF->0
//  overrun_count  out  16           samples overwritten before launch, saturates at 0xFFFF
//  timeout_err    out  1            sticky; busy never rose within ACK_TIMEOUT
//  sched_idle     out  1            FSM in IDLE
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - holding regs = 0; pending = 0; dac_data = {N_CH{16'h8000}} (midscale).
//   - dac_start = 0; counters = 0; timeout_err = 0; state = IDLE.
//  Per-channel slot:
//   - ch_valid[i] at edge k loads hold[i] and sets pending[i].
//   - If pending[i] is already set and the slot is not being consumed in that cycle, overrun_count += 1 (saturating).
//   - Multiple channels overrunning in the same cycle add their total count.
//  FSM states: IDLE, LAUNCH, WAIT_HI, WAIT_LO, GAP.
//   - IDLE -> LAUNCH when enable & ch_mask!=0 & (pending & ch_mask)==ch_mask.
//   - LAUNCH (1 cycle), registered outputs:
//     - dac_start=1.
//     - dac_data[i] = hold[i] ^ 16'h8000 for masked channels; unmasked channels keep their previous word.
//     - pending[i] cleared for masked i; a same-cycle ch_valid[i] wins: new data kept, pending stays 1, no overrun.
//     - frame_count += 1.
//   - WAIT_HI: wait for dac_busy=1 -> WAIT_LO. After ACK_TIMEOUT cycles: timeout_err=1 -> IDLE (frame still counted).
//   - WAIT_LO: dac_busy=0 -> GAP. No timeout here.
//   - GAP: count MIN_GAP cycles -> IDLE.
//  Latency: ch_valid at edge k, all masked channels fresh, FSM in IDLE -> dac_start high in the cycle after edge k+1.
//  enable deasserted mid-frame: the frame finishes through GAP; pending keeps accumulating.
//  ch_mask changes: sampled only in IDLE and LAUNCH.
//  dac_busy already high in IDLE: launch still occurs; WAIT_HI exits on the next cycle.
//  DATA_W != 16: offset conversion inverts MSB of DATA_W.
// STRUCTURE
//  dac_sched_pkg (`include): state encodings, MIDSCALE constant, counter widths.
//  Sub-module dac_channel_slot: one hold register + pending bit + overrun flag, instantiated N_CH times via generate.
//  Top level: FSM, gap/timeout counter (shared, 8 bits min), output registers, counters.
// TESTING
//  1 Mask=4'b1111, valid all chans together data=0 -> one dac_start, dac_data=4x16'h8000, frame_count=1.
//  2 Mask=4'b0011, ch0 valid t0, ch1 valid t0+5 -> dac_start 2 cycles after ch1 strobe; ch2/ch3 words unchanged.
//  3 ch0 strobed 3x while serializer busy (busy held 100 cycles) -> overrun_count=2; frame carries last value.
//  4 dac_busy held 0 after start -> timeout_err=1 at start+ACK_TIMEOUT, back to IDLE, next frame launches normally.
//  5 Busy falls then valid ready immediately -> next dac_start exactly MIN_GAP+1 cycles after busy fall.
//  6 reset_n low during WAIT_LO -> outputs immediately at reset values; after release, no spurious dac_start.

Source files
------------

// File: rtl/dac_frame_scheduler_pkg.sv
// Shared types and constants for the DAC frame scheduler.
package dac_frame_scheduler_pkg;

   // Scheduler FSM states
   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_HI,
      S_WAIT_LO,
      S_GAP
   } sched_state_e;

   // Minimum width of the shared gap/timeout counter (MIN_GAP is limited to 255)
   localparam int CNT_MIN_W  = 8;
   // Width of the frame and overrun status counters
   localparam int STAT_CNT_W = 16;

endpackage

// File: rtl/dac_frame_scheduler_slot.sv
// One channel slot: latest sample, fresh flag and overrun detection.
module dac_frame_scheduler_slot #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid,
   input  logic [DATA_W-1:0] din,
   input  logic              consume,
   output logic [DATA_W-1:0] hold,
   output logic              pending,
   output logic              overrun
);

   // Latch new samples; a strobe in the launch cycle wins over the clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold    <= '0;
         pending <= 1'b0;
      end else begin
         if (valid) begin
            hold    <= din;
            pending <= 1'b1;
         end else if (consume) begin
            pending <= 1'b0;
         end
      end
   end

   // A fresh sample is lost only if it was never handed to a frame
   assign overrun = valid & pending & ~consume;

endmodule

// File: rtl/dac_frame_scheduler.sv
// Collects per-channel samples and launches one frame at a time into the
// shared DAC serializer, pacing launches on its busy handshake.
module dac_frame_scheduler
   import dac_frame_scheduler_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int DATA_W      = 16,
   parameter int MIN_GAP     = 8,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       enable,
   input  logic [N_CH-1:0]            ch_mask,
   input  logic [N_CH*DATA_W-1:0]     ch_data,
   input  logic [N_CH-1:0]            ch_valid,
   input  logic                       dac_busy,
   output logic                       dac_start,
   output logic [N_CH*DATA_W-1:0]     dac_data,
   output logic [STAT_CNT_W-1:0]      frame_count,
   output logic [STAT_CNT_W-1:0]      overrun_count,
   output logic                       timeout_err,
   output logic                       sched_idle
);

   localparam int CNT_W = ($clog2(ACK_TIMEOUT) + 1 > CNT_MIN_W) ?
                          $clog2(ACK_TIMEOUT) + 1 : CNT_MIN_W;
   localparam int OVR_W = $clog2(N_CH + 1);
   localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

   logic [1:0]                    rst_pipe;
   logic                          rst_sync_n;
   sched_state_e                  state_q, state_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic                          launch_go;
   logic                          timeout_set;
   logic [N_CH-1:0][DATA_W-1:0]   hold;
   logic [N_CH-1:0]               pending;
   logic [N_CH-1:0]               overrun;
   logic [N_CH-1:0]               consume;
   logic [OVR_W-1:0]              ovr_inc;
   logic [STAT_CNT_W:0]           ovr_sum;

   // Reset asserts immediately, releases two edges later in the clk domain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_pipe <= '0;
      else          rst_pipe <= {rst_pipe[0], 1'b1};
   end
   assign rst_sync_n = rst_pipe[1];

   // Masked slots are consumed on the edge that enters LAUNCH
   assign consume = launch_go ? ch_mask : '0;

   for (genvar i = 0; i < N_CH; i++) begin : g_slot
      dac_frame_scheduler_slot #(.DATA_W(DATA_W)) u_slot (
         .clk     (clk),
         .rst_n   (rst_sync_n),
         .valid   (ch_valid[i]),
         .din     (ch_data[i*DATA_W +: DATA_W]),
         .consume (consume[i]),
         .hold    (hold[i]),
         .pending (pending[i]),
         .overrun (overrun[i])
      );
   end

   // FSM state and shared gap/timeout counter
   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: launch when every masked channel is fresh, then track busy
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      launch_go   = 1'b0;
      timeout_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable && (ch_mask != '0) && ((pending & ch_mask) == ch_mask)) begin
               launch_go = 1'b1;
               state_d   = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            state_d = S_WAIT_HI;
            cnt_d   = '0;
         end
         S_WAIT_HI: begin
            // timeout_err lands exactly ACK_TIMEOUT cycles after dac_start
            if (dac_busy) begin
               state_d = S_WAIT_LO;
            end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 2)) begin
               timeout_set = 1'b1;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT_LO: begin
            // the cycle where busy is seen low counts as the first idle cycle
            if (!dac_busy) begin
               state_d = S_GAP;
               cnt_d   = CNT_W'(1);
            end
         end
         S_GAP: begin
            if (cnt_q >= CNT_W'(MIN_GAP - 1)) state_d = S_IDLE;
            else                             cnt_d   = cnt_q + CNT_W'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Number of slots overwritten this cycle
   always_comb begin
      ovr_inc = '0;
      for (int i = 0; i < N_CH; i++) ovr_inc = ovr_inc + OVR_W'(overrun[i]);
      ovr_sum = {1'b0, overrun_count} + (STAT_CNT_W+1)'(ovr_inc);
   end

   // Registered launch outputs and status counters
   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         dac_start     <= 1'b0;
         dac_data      <= {N_CH{MIDSCALE}};
         frame_count   <= '0;
         overrun_count <= '0;
         timeout_err   <= 1'b0;
      end else begin
         dac_start     <= launch_go;
         overrun_count <= ovr_sum[STAT_CNT_W] ? '1 : ovr_sum[STAT_CNT_W-1:0];
         if (launch_go) begin
            frame_count <= frame_count + STAT_CNT_W'(1);
            for (int i = 0; i < N_CH; i++) begin
               if (ch_mask[i]) dac_data[i*DATA_W +: DATA_W] <= hold[i] ^ MIDSCALE;
            end
         end
         if (timeout_set) timeout_err <= 1'b1;
      end
   end

   assign sched_idle = (state_q == S_IDLE);

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Directed + randomized bench for dac_frame_scheduler with a slot-level model.
module tb_dac_frame_scheduler;

   localparam int N_CH        = 4;
   localparam int DATA_W      = 16;
   localparam int MIN_GAP     = 8;
   localparam int ACK_TIMEOUT = 64;

   logic                   clk = 1'b0;
   logic                   reset_n = 1'b0;
   logic                   enable = 1'b0;
   logic [N_CH-1:0]        ch_mask = '0;
   logic [N_CH*DATA_W-1:0] ch_data = '0;
   logic [N_CH-1:0]        ch_valid = '0;
   logic                   dac_busy = 1'b0;
   logic                   dac_start;
   logic [N_CH*DATA_W-1:0] dac_data;
   logic [15:0]            frame_count;
   logic [15:0]            overrun_count;
   logic                   timeout_err;
   logic                   sched_idle;

   int errors = 0;
   int checks = 0;

   // Reference model: latest sample per channel, fresh flag, frame words
   logic [DATA_W-1:0] m_hold [N_CH];
   logic [DATA_W-1:0] m_dac  [N_CH];
   logic              m_pend [N_CH];
   int                m_ovr;
   int                m_frames;

   dac_frame_scheduler #(
      .N_CH(N_CH), .DATA_W(DATA_W), .MIN_GAP(MIN_GAP), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .ch_mask       (ch_mask),
      .ch_data       (ch_data),
      .ch_valid      (ch_valid),
      .dac_busy      (dac_busy),
      .dac_start     (dac_start),
      .dac_data      (dac_data),
      .frame_count   (frame_count),
      .overrun_count (overrun_count),
      .timeout_err   (timeout_err),
      .sched_idle    (sched_idle)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) begin
         m_hold[i] = '0;
         m_pend[i] = 1'b0;
         m_dac[i]  = 16'h8000;
      end
      m_ovr    = 0;
      m_frames = 0;
   endtask

   task automatic model_strobe(input logic [N_CH-1:0] v, input logic [N_CH*DATA_W-1:0] d);
      for (int i = 0; i < N_CH; i++) begin
         if (v[i]) begin
            if (m_pend[i] && m_ovr < 65535) m_ovr++;
            m_hold[i] = d[i*DATA_W +: DATA_W];
            m_pend[i] = 1'b1;
         end
      end
   endtask

   task automatic model_launch(input logic [N_CH-1:0] m);
      for (int i = 0; i < N_CH; i++) begin
         if (m[i]) begin
            m_dac[i]  = m_hold[i] ^ 16'h8000;
            m_pend[i] = 1'b0;
         end
      end
      m_frames = (m_frames + 1) % 65536;
   endtask

   function automatic logic [N_CH*DATA_W-1:0] exp_dac();
      logic [N_CH*DATA_W-1:0] v;
      for (int i = 0; i < N_CH; i++) v[i*DATA_W +: DATA_W] = m_dac[i];
      return v;
   endfunction

   // Called at posedge+1: present a one-cycle strobe
   task automatic strobe(input logic [N_CH-1:0] v, input logic [N_CH*DATA_W-1:0] d);
      ch_valid = v;
      ch_data  = d;
      @(posedge clk); #1;
      ch_valid = '0;
   endtask

   task automatic wait_start(input int max, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         @(posedge clk); #1;
         if (dac_start) begin
            n = i;
            break;
         end
      end
   endtask

   // Busy for nb cycles, then let the gap expire
   task automatic serve(input int nb);
      dac_busy = 1'b1;
      repeat (nb) @(posedge clk);
      #1 dac_busy = 1'b0;
      repeat (MIN_GAP + 3) @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int spurious;
      logic [N_CH*DATA_W-1:0] d;
      logic [N_CH-1:0] m;

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_start", dac_start, 0);
      chk("rst_data", dac_data, exp_dac());
      chk("rst_frames", frame_count, 0);
      chk("rst_ovr", overrun_count, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_idle", sched_idle, 1);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // 1: all channels together, zero data -> midscale frame
      enable  = 1'b1;
      ch_mask = 4'b1111;
      model_strobe(4'b1111, '0);
      strobe(4'b1111, '0);
      wait_start(5, n);
      chk("t1_latency", 64'(n), 1);
      model_launch(4'b1111);
      chk("t1_data", dac_data, {4{16'h8000}});
      chk("t1_frames", frame_count, 1);
      serve(4);
      chk("t1_idle", sched_idle, 1);

      // 2: two-channel mask, staggered strobes
      ch_mask = 4'b0011;
      d = {$urandom, $urandom};
      model_strobe(4'b0001, d);
      strobe(4'b0001, d);
      repeat (4) @(posedge clk);
      #1;
      chk("t2_no_early", dac_start, 0);
      chk("t2_frames_hold", frame_count, 64'(m_frames));
      d = {$urandom, $urandom};
      model_strobe(4'b0010, d);
      strobe(4'b0010, d);
      wait_start(5, n);
      chk("t2_latency", 64'(n), 1);
      model_launch(4'b0011);
      chk("t2_data", dac_data, exp_dac());
      chk("t2_upper_mid", 64'(dac_data[63:32]), {2{16'h8000}});
      serve(2);

      // 3 + 5: overruns while busy, relaunch MIN_GAP+1 after busy falls
      ch_mask = 4'b0001;
      d = {$urandom, $urandom};
      model_strobe(4'b0001, d);
      strobe(4'b0001, d);
      wait_start(5, n);
      chk("t3_latency", 64'(n), 1);
      model_launch(4'b0001);
      chk("t3_data0", dac_data, exp_dac());
      dac_busy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         repeat (5) @(posedge clk);
         #1;
         d = {$urandom, $urandom};
         model_strobe(4'b0001, d);
         strobe(4'b0001, d);
      end
      chk("t3_ovr", overrun_count, 2);
      chk("t3_still_busy", sched_idle, 0);
      repeat (70) @(posedge clk);
      #1 dac_busy = 1'b0;
      wait_start(MIN_GAP + 20, n);
      chk("t5_gap_latency", 64'(n), MIN_GAP + 1);
      model_launch(4'b0001);
      chk("t3_last_value", dac_data, exp_dac());
      chk("t3_frames", frame_count, 64'(m_frames));
      serve(3);

      // Strobe on the launch edge: new data kept for the next frame, no overrun
      d = {$urandom, $urandom};
      model_strobe(4'b0001, d);
      strobe(4'b0001, d);
      d = {$urandom, $urandom};
      ch_valid = 4'b0001;
      ch_data  = d;
      @(posedge clk); #1;
      ch_valid = '0;
      chk("tw_start", dac_start, 1);
      model_launch(4'b0001);
      model_strobe(4'b0001, d);
      chk("tw_data", dac_data, exp_dac());
      chk("tw_ovr", overrun_count, 64'(m_ovr));
      dac_busy = 1'b1;
      repeat (3) @(posedge clk);
      #1 dac_busy = 1'b0;
      wait_start(MIN_GAP + 5, n);
      chk("tw_relaunch", 64'(n), MIN_GAP + 1);
      model_launch(4'b0001);
      chk("tw_data2", dac_data, exp_dac());
      serve(3);

      // 4: busy never rises -> timeout, then a normal frame
      d = {$urandom, $urandom};
      model_strobe(4'b0001, d);
      strobe(4'b0001, d);
      wait_start(5, n);
      model_launch(4'b0001);
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk); #1;
         if (timeout_err) begin
            n = i;
            break;
         end
      end
      chk("t4_timeout_at", 64'(n), ACK_TIMEOUT);
      chk("t4_idle", sched_idle, 1);
      chk("t4_frames", frame_count, 64'(m_frames));
      d = {$urandom, $urandom};
      model_strobe(4'b0001, d);
      strobe(4'b0001, d);
      wait_start(5, n);
      chk("t4_next_latency", 64'(n), 1);
      model_launch(4'b0001);
      chk("t4_next_data", dac_data, exp_dac());
      serve(3);
      chk("t4_sticky", timeout_err, 1);

      // enable low holds off a ready frame
      enable = 1'b0;
      d = {$urandom, $urandom};
      model_strobe(4'b0001, d);
      strobe(4'b0001, d);
      repeat (5) @(posedge clk);
      #1;
      chk("ten_hold_frames", frame_count, 64'(m_frames));
      chk("ten_hold_idle", sched_idle, 1);
      enable = 1'b1;
      wait_start(5, n);
      chk("ten_latency", 64'(n), 1);
      model_launch(4'b0001);
      chk("ten_data", dac_data, exp_dac());
      serve(2);

      // 6: reset in WAIT_LO with a pending sample
      d = {$urandom, $urandom};
      model_strobe(4'b0001, d);
      strobe(4'b0001, d);
      wait_start(5, n);
      model_launch(4'b0001);
      dac_busy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      d = {$urandom, $urandom};
      strobe(4'b0001, d);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      chk("t6_start", dac_start, 0);
      chk("t6_data", dac_data, exp_dac());
      chk("t6_frames", frame_count, 0);
      chk("t6_ovr", overrun_count, 0);
      chk("t6_timeout", timeout_err, 0);
      chk("t6_idle", sched_idle, 1);
      dac_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      spurious = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (dac_start) spurious++;
      end
      chk("t6_no_spurious", 64'(spurious), 0);

      // Randomized frames with multi-channel overruns during busy
      for (int it = 0; it < 4; it++) begin
         m = 4'($urandom_range(1, 15));
         ch_mask = m;
         d = {$urandom, $urandom};
         model_strobe(m, d);
         strobe(m, d);
         wait_start(5, n);
         chk("rnd_latency", 64'(n), 1);
         model_launch(m);
         chk("rnd_data", dac_data, exp_dac());
         dac_busy = 1'b1;
         repeat (3) @(posedge clk);
         #1;
         d = {$urandom, $urandom};
         model_strobe(m, d);
         strobe(m, d);
         d = {$urandom, $urandom};
         model_strobe(m, d);
         strobe(m, d);
         chk("rnd_ovr", overrun_count, 64'(m_ovr));
         repeat ($urandom_range(1, 10)) @(posedge clk);
         #1 dac_busy = 1'b0;
         wait_start(MIN_GAP + 5, n);
         chk("rnd_gap", 64'(n), MIN_GAP + 1);
         model_launch(m);
         chk("rnd_data2", dac_data, exp_dac());
         chk("rnd_frames", frame_count, 64'(m_frames));
         serve($urandom_range(1, 6));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
